// File: rtl/pc_sequencer.sv
// PC stage: holds the PC, fetches from imem, handles stall/redirect/halt.
// Optional macro: PC_ALIGN_CHECK_EN traps misaligned redirects to HALTED.
module pc_sequencer #(
  parameter int             n        = 32,
  parameter logic [n-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         halt,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ready,
  output logic [n-1:0] pc,
  output logic         fetch_valid,
  output logic [n-1:0] fetch_pc,
  output logic [31:0]  fetch_count,
  output logic         halted,
  output logic         fault
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HALTED
  } state_t;

  state_t         r_state;
  logic [n-1:0]   r_pc;
  logic           r_req;
  logic           r_fv;
  logic [n-1:0]   r_fpc;
  logic [31:0]    r_cnt;
  logic           r_halted;
  logic [n-1:0]   w_inc;

  assign w_inc = r_pc + n'(4);

`ifdef PC_ALIGN_CHECK_EN
  logic r_fault;
  logic w_misal;
  assign w_misal = (redirect_pc[1:0] != 2'b00);
  assign fault   = r_fault;
`else
  logic [n-1:0] w_tgt;
  // low two bits are dropped so the PC stays word-aligned
  assign w_tgt = redirect_pc & ~{{(n-2){1'b0}}, 2'b11};
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_fv     <= 1'b0;
      r_fpc    <= '0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      r_fault  <= 1'b0;
`endif
    end else begin
      r_fv <= 1'b0;
      unique case (r_state)
        S_BOOT, S_REQ: begin
          if (halt) begin
            r_state  <= S_HALTED;
            r_req    <= 1'b0;
            r_halted <= 1'b1;
          end else if (redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
            if (w_misal) begin
              r_state  <= S_HALTED;
              r_req    <= 1'b0;
              r_halted <= 1'b1;
              r_fault  <= 1'b1;
            end else begin
              r_pc    <= redirect_pc;
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
`else
            r_pc    <= w_tgt;
            r_state <= S_REQ;
            r_req   <= 1'b1;
`endif
          end else if (r_state == S_BOOT) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end else if (stall) begin
            r_state <= S_REQ;
          end else if (imem_ready) begin
            r_fpc <= r_pc;
            r_pc  <= w_inc;
            r_cnt <= r_cnt + 32'd1;
            r_fv  <= 1'b1;
          end
        end
        S_HALTED: begin
          r_req    <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = r_req;
  assign fetch_valid = r_fv;
  assign fetch_pc    = r_fpc;
  assign fetch_count = r_cnt;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; covers both PC_ALIGN_CHECK_EN builds.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_count;
  logic        halted;
  logic        fault;

  int tests;
  int fails;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC   = 32'h0;
  localparam logic        MIS_FLT  = 1'b1;
  localparam logic        MIS_HALT = 1'b1;
  localparam logic        MIS_REQ  = 1'b0;
`else
  localparam logic [31:0] MIS_PC   = 32'h100;
  localparam logic        MIS_FLT  = 1'b0;
  localparam logic        MIS_HALT = 1'b0;
  localparam logic        MIS_REQ  = 1'b1;
`endif

  pc_sequencer #(.n(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_count    (fetch_count),
    .halted         (halted),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, 64'(pc), 64'h0);
    chk({tag, ".addr"}, 64'(imem_addr), 64'h0);
    chk({tag, ".req"}, 64'(imem_req), 64'h0);
    chk({tag, ".fv"}, 64'(fetch_valid), 64'h0);
    chk({tag, ".fpc"}, 64'(fetch_pc), 64'h0);
    chk({tag, ".cnt"}, 64'(fetch_count), 64'h0);
    chk({tag, ".halted"}, 64'(halted), 64'h0);
    chk({tag, ".fault"}, 64'(fault), 64'h0);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset          = 1'b1;
    stall          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ready     = 1'b0;
    #2;
    chk_reset("rst");
    step();
    step();
    reset      = 1'b0;
    imem_ready = 1'b1;

    // BOOT edge: no fetch accepted yet
    step();
    chk("boot.req", 64'(imem_req), 64'h1);
    chk("boot.fv", 64'(fetch_valid), 64'h0);
    chk("boot.pc", 64'(pc), 64'h0);

    for (int i = 0; i < 4; i++) begin
      step();
      chk("run.fv", 64'(fetch_valid), 64'h1);
      chk("run.fpc", 64'(fetch_pc), 64'(i * 4));
    end
    chk("run.pc", 64'(pc), 64'h10);
    chk("run.addr", 64'(imem_addr), 64'h10);
    chk("run.cnt", 64'(fetch_count), 64'h4);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.pc", 64'(pc), 64'h10);
      chk("stall.fv", 64'(fetch_valid), 64'h0);
      chk("stall.req", 64'(imem_req), 64'h1);
    end
    stall = 1'b0;
    step();
    chk("resume.fv", 64'(fetch_valid), 64'h1);
    chk("resume.fpc", 64'(fetch_pc), 64'h10);
    chk("resume.pc", 64'(pc), 64'h14);
    chk("resume.cnt", 64'(fetch_count), 64'h5);

    // redirect wins over ready and stall
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    stall          = 1'b1;
    step();
    chk("redir.fv", 64'(fetch_valid), 64'h0);
    chk("redir.pc", 64'(pc), 64'h100);
    chk("redir.cnt", 64'(fetch_count), 64'h5);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    step();
    chk("tgt.fv", 64'(fetch_valid), 64'h1);
    chk("tgt.fpc", 64'(fetch_pc), 64'h100);
    chk("tgt.pc", 64'(pc), 64'h104);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    chk("top.pc", 64'(pc), 64'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    chk("wrap.fpc", 64'(fetch_pc), 64'hFFFF_FFFC);
    chk("wrap.pc", 64'(pc), 64'h0);
    chk("wrap.cnt", 64'(fetch_count), 64'h7);
    chk("wrap.fault", 64'(fault), 64'h0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    chk("mis.pc", 64'(pc), 64'(MIS_PC));
    chk("mis.fault", 64'(fault), 64'(MIS_FLT));
    chk("mis.halted", 64'(halted), 64'(MIS_HALT));
    chk("mis.req", 64'(imem_req), 64'(MIS_REQ));
    chk("mis.fv", 64'(fetch_valid), 64'h0);

    // halt beats a simultaneous redirect and ready
    halt        = 1'b1;
    redirect_pc = 32'h200;
    step();
    chk("halt.halted", 64'(halted), 64'h1);
    chk("halt.req", 64'(imem_req), 64'h0);
    chk("halt.pc", 64'(pc), 64'(MIS_PC));
    chk("halt.cnt", 64'(fetch_count), 64'h7);
    halt = 1'b0;
    step();
    step();
    chk("hold.pc", 64'(pc), 64'(MIS_PC));
    chk("hold.halted", 64'(halted), 64'h1);
    chk("hold.fv", 64'(fetch_valid), 64'h0);
    chk("hold.cnt", 64'(fetch_count), 64'h7);

    // restart, then reset asynchronously mid-fetch
    redirect_valid = 1'b0;
    reset          = 1'b1;
    #2;
    chk_reset("rst2");
    step();
    reset = 1'b0;
    step();
    step();
    step();
    chk("pre.fv", 64'(fetch_valid), 64'h1);
    chk("pre.pc", 64'(pc), 64'h8);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("async");
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
